// File: rtl/hog_svm_pkg.sv
// Constants and types shared by the HOG/SVM window controller and detection collector.
package hog_svm_pkg;

    // Slide-window grid: 29 rows x 39 columns, indices 0..1130.
    localparam int unsigned SW_W      = 11;
    localparam int unsigned SC_W      = 16;
    localparam int unsigned COL_N     = 39;
    localparam int unsigned ROW_N     = 29;
    localparam int unsigned MAX_SW    = 1130;
    localparam int unsigned ROW_W     = 5;
    localparam int unsigned COL_W     = 6;
    localparam int unsigned FIFO_AW   = 4;

    // floor(id/39) == (id*1681)>>16 holds exactly for every id up to MAX_SW.
    localparam int unsigned DIV39_MUL = 1681;
    localparam int unsigned DIV39_SH  = 16;
    localparam int unsigned PROD_W    = 22;

    typedef struct packed {
        logic [ROW_W-1:0]        row;
        logic [COL_W-1:0]        col;
        logic signed [SC_W-1:0]  score;
    } det_hit_t;

    typedef enum logic {
        ACC_ARMED = 1'b0,
        ACC_RUN   = 1'b1
    } acc_state_e;

    function automatic logic [ROW_W-1:0] div39(input logic [SW_W-1:0] id);
        logic [PROD_W-1:0] prod;
        prod = PROD_W'(id) * PROD_W'(DIV39_MUL);
        return ROW_W'(prod >> DIV39_SH);
    endfunction

endpackage

// File: rtl/det_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO succeeds when a pop happens that cycle.
module det_fifo #(
    parameter int unsigned W  = 27,
    parameter int unsigned AW = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         empty_o,
    output logic         full_o
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          empty_q, full_q;
    logic          do_push, do_pop;

    assign do_pop  = pop_i && !empty_q;
    assign do_push = push_i && (!full_q || do_pop);

    always_comb begin
        cnt_d = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            cnt_q   <= cnt_d;
            empty_q <= (cnt_d == '0);
            full_q  <= (cnt_d == (AW+1)'(DEPTH));
        end
    end

    // Storage is not reset; the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (rst && do_push) mem_q[wr_q] <= din_i;
    end

    assign dout_o  = empty_q ? '0 : mem_q[rd_q];
    assign empty_o = empty_q;
    assign full_o  = full_q;

endmodule

// File: rtl/svm_det_collect.sv
// Detection collector: maps SVM window scores to (row, col), queues threshold hits and
// reports per-frame hit count, overflow and best-scoring window.
module svm_det_collect
    import hog_svm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [SW_W-1:0]  i_sw_id,
    input  logic [SC_W-1:0]  i_score,
    input  logic [SC_W-1:0]  i_thr,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [ROW_W-1:0] o_row,
    output logic [COL_W-1:0] o_col,
    output logic [SC_W-1:0]  o_score,
    output logic             frame_done,
    output logic [SW_W-1:0]  frame_hits,
    output logic             frame_ovf,
    output logic [ROW_W-1:0] best_row,
    output logic [COL_W-1:0] best_col,
    output logic [SC_W-1:0]  best_score,
    output logic             best_hit
);

    // Pipeline stage registers
    logic             v0_q;
    logic [SW_W-1:0]  id0_q;
    logic [SC_W-1:0]  sc0_q, thr0_q;

    logic             v1_q;
    logic [SW_W-1:0]  id1_q;
    logic [ROW_W-1:0] row1_q, row1_d;
    logic [SC_W-1:0]  sc1_q, thr1_q;

    logic             v2_q;
    logic [SW_W-1:0]  id2_q;
    det_hit_t         win2_q;
    logic             hit2_q, hit2_d;
    logic [COL_W-1:0] col2_d;

    // Accumulators and held frame summary
    acc_state_e       state_q, state_d;
    logic [SW_W-1:0]  acc_hits_q, acc_hits_d;
    logic             acc_ovf_q, acc_ovf_d;
    det_hit_t         acc_best_q, acc_best_d;
    logic             acc_bhit_q, acc_bhit_d;

    logic             done_q, done_d;
    logic [SW_W-1:0]  sum_hits_q, sum_hits_d;
    logic             sum_ovf_q, sum_ovf_d;
    det_hit_t         sum_best_q, sum_best_d;
    logic             sum_bhit_q, sum_bhit_d;

    // FIFO interface
    det_hit_t         head;
    logic             fifo_empty, fifo_full;
    logic             pop_c, push_c, drop_c;

    always_comb begin
        row1_d = div39(id0_q);
        col2_d = COL_W'(id1_q - SW_W'(row1_q) * SW_W'(COL_N));
        hit2_d = ($signed(sc1_q) >= $signed(thr1_q));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            v0_q   <= 1'b0;
            id0_q  <= '0;
            sc0_q  <= '0;
            thr0_q <= '0;
            v1_q   <= 1'b0;
            id1_q  <= '0;
            row1_q <= '0;
            sc1_q  <= '0;
            thr1_q <= '0;
            v2_q   <= 1'b0;
            id2_q  <= '0;
            win2_q <= '0;
            hit2_q <= 1'b0;
        end else begin
            v0_q   <= i_valid;
            id0_q  <= i_sw_id;
            sc0_q  <= i_score;
            thr0_q <= i_thr;

            v1_q   <= v0_q;
            id1_q  <= id0_q;
            row1_q <= row1_d;
            sc1_q  <= sc0_q;
            thr1_q <= thr0_q;

            v2_q       <= v1_q;
            id2_q      <= id1_q;
            win2_q.row <= row1_q;
            win2_q.col <= col2_d;
            win2_q.score <= sc1_q;
            hit2_q     <= hit2_d;
        end
    end

    assign pop_c  = !fifo_empty && i_ready;
    assign push_c = v2_q && hit2_q;
    assign drop_c = push_c && fifo_full && !pop_c;

    det_fifo #(
        .W  ($bits(det_hit_t)),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_c),
        .din_i   (win2_q),
        .pop_i   (i_ready),
        .dout_o  (head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // Accumulator FSM: a window ending the frame latches the summary and re-arms
    // so the very next S2 window starts the new frame from cleared state.
    always_comb begin
        state_d    = state_q;
        acc_hits_d = acc_hits_q;
        acc_ovf_d  = acc_ovf_q;
        acc_best_d = acc_best_q;
        acc_bhit_d = acc_bhit_q;
        done_d     = 1'b0;
        sum_hits_d = sum_hits_q;
        sum_ovf_d  = sum_ovf_q;
        sum_best_d = sum_best_q;
        sum_bhit_d = sum_bhit_q;

        if (v2_q) begin
            state_d = ACC_RUN;
            if (hit2_q && (acc_hits_q != '1)) acc_hits_d = acc_hits_q + SW_W'(1);
            if (drop_c) acc_ovf_d = 1'b1;
            if ((state_q == ACC_ARMED) || ($signed(win2_q.score) > $signed(acc_best_q.score))) begin
                acc_best_d = win2_q;
                acc_bhit_d = hit2_q;
            end

            if (id2_q == SW_W'(MAX_SW)) begin
                done_d     = 1'b1;
                sum_hits_d = acc_hits_d;
                sum_ovf_d  = acc_ovf_d;
                sum_best_d = acc_best_d;
                sum_bhit_d = acc_bhit_d;
                state_d    = ACC_ARMED;
                acc_hits_d = '0;
                acc_ovf_d  = 1'b0;
                acc_best_d = '0;
                acc_bhit_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ACC_ARMED;
            acc_hits_q <= '0;
            acc_ovf_q  <= 1'b0;
            acc_best_q <= '0;
            acc_bhit_q <= 1'b0;
            done_q     <= 1'b0;
            sum_hits_q <= '0;
            sum_ovf_q  <= 1'b0;
            sum_best_q <= '0;
            sum_bhit_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_hits_q <= acc_hits_d;
            acc_ovf_q  <= acc_ovf_d;
            acc_best_q <= acc_best_d;
            acc_bhit_q <= acc_bhit_d;
            done_q     <= done_d;
            sum_hits_q <= sum_hits_d;
            sum_ovf_q  <= sum_ovf_d;
            sum_best_q <= sum_best_d;
            sum_bhit_q <= sum_bhit_d;
        end
    end

    assign o_valid    = !fifo_empty;
    assign o_row      = head.row;
    assign o_col      = head.col;
    assign o_score    = head.score;
    assign frame_done = done_q;
    assign frame_hits = sum_hits_q;
    assign frame_ovf  = sum_ovf_q;
    assign best_row   = sum_best_q.row;
    assign best_col   = sum_best_q.col;
    assign best_score = sum_best_q.score;
    assign best_hit   = sum_bhit_q;

endmodule

// File: tb/tb_svm_det_collect.sv
// Scoreboard bench for svm_det_collect: directed corner cases plus randomized frames
// against a division/modulo reference model.
module tb_svm_det_collect;
    import hog_svm_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_valid, i_ready;
    logic [SW_W-1:0]  i_sw_id;
    logic [SC_W-1:0]  i_score, i_thr;
    logic             o_valid;
    logic [ROW_W-1:0] o_row;
    logic [COL_W-1:0] o_col;
    logic [SC_W-1:0]  o_score;
    logic             frame_done;
    logic [SW_W-1:0]  frame_hits;
    logic             frame_ovf;
    logic [ROW_W-1:0] best_row;
    logic [COL_W-1:0] best_col;
    logic [SC_W-1:0]  best_score;
    logic             best_hit;

    svm_det_collect dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .i_sw_id    (i_sw_id),
        .i_score    (i_score),
        .i_thr      (i_thr),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_row      (o_row),
        .o_col      (o_col),
        .o_score    (o_score),
        .frame_done (frame_done),
        .frame_hits (frame_hits),
        .frame_ovf  (frame_ovf),
        .best_row   (best_row),
        .best_col   (best_col),
        .best_score (best_score),
        .best_hit   (best_hit)
    );

    always #5 clk = ~clk;

    typedef struct { int row; int col; int score; } exp_hit_t;
    typedef struct { int hits; int ovf; int row; int col; int score; int bhit; } exp_sum_t;

    exp_hit_t hq[$];
    exp_sum_t sq[$];
    int nchecks = 0;
    int nerr    = 0;

    // Frame-level reference state
    int m_hits, m_brow, m_bcol, m_bscore;
    bit m_ovf, m_bhit, m_armed;
    bit rand_ready = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        nchecks++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_hits = 0; m_ovf = 0; m_armed = 1;
        m_brow = 0; m_bcol = 0; m_bscore = 0; m_bhit = 0;
    endtask

    // keep=0 means the bench knows this hit will find the FIFO full and be dropped.
    task automatic send(input int id, input int score, input int thr, input bit keep);
        exp_hit_t e;
        exp_sum_t s;
        bit hit;
        @(posedge clk); #1;
        i_valid = 1'b1;
        i_sw_id = SW_W'(id);
        i_score = SC_W'(score);
        i_thr   = SC_W'(thr);
        if (rand_ready) i_ready = 1'($urandom_range(0, 1));
        hit = (score >= thr);
        if (hit) begin
            if (m_hits < 2047) m_hits++;
            if (keep) begin
                e.row = id / 39; e.col = id % 39; e.score = score;
                hq.push_back(e);
            end else m_ovf = 1;
        end
        if (m_armed || score > m_bscore) begin
            m_brow = id / 39; m_bcol = id % 39; m_bscore = score; m_bhit = hit;
        end
        m_armed = 0;
        if (id == int'(MAX_SW)) begin
            s.hits = m_hits; s.ovf = int'(m_ovf); s.row = m_brow; s.col = m_bcol;
            s.score = m_bscore; s.bhit = int'(m_bhit);
            sq.push_back(s);
            model_clear();
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            i_valid = 1'b0;
            if (rand_ready) i_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic drain();
        i_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (hq.size() == 0 && sq.size() == 0 && !o_valid) break;
            @(posedge clk); #1;
        end
        check("drain_hits_left", hq.size(), 0);
        check("drain_frames_left", sq.size(), 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_o_valid"}, int'(o_valid), 0);
        check({tag, "_frame_done"}, int'(frame_done), 0);
        check({tag, "_frame_ovf"}, int'(frame_ovf), 0);
        check({tag, "_best_hit"}, int'(best_hit), 0);
        check({tag, "_frame_hits"}, int'(frame_hits), 0);
        check({tag, "_best_row"}, int'(best_row), 0);
        check({tag, "_best_col"}, int'(best_col), 0);
        check({tag, "_best_score"}, int'(best_score), 0);
        check({tag, "_o_row"}, int'(o_row), 0);
        check({tag, "_o_col"}, int'(o_col), 0);
        check({tag, "_o_score"}, int'(o_score), 0);
    endtask

    // Monitor: compare every accepted hit and every frame summary against the queues.
    exp_hit_t me;
    exp_sum_t ms;
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (o_valid && i_ready) begin
                if (hq.size() == 0) begin
                    nchecks++; nerr++;
                    $display("FAIL unexpected_hit: row %0d col %0d score %0d, none expected",
                             o_row, o_col, $signed(o_score));
                end else begin
                    me = hq.pop_front();
                    check("hit_row", int'(o_row), me.row);
                    check("hit_col", int'(o_col), me.col);
                    check("hit_score", int'($signed(o_score)), me.score);
                end
            end
            if (frame_done) begin
                if (sq.size() == 0) begin
                    nchecks++; nerr++;
                    $display("FAIL unexpected_frame_done: hits %0d", frame_hits);
                end else begin
                    ms = sq.pop_front();
                    check("frame_hits", int'(frame_hits), ms.hits);
                    check("frame_ovf", int'(frame_ovf), ms.ovf);
                    check("best_row", int'(best_row), ms.row);
                    check("best_col", int'(best_col), ms.col);
                    check("best_score", int'($signed(best_score)), ms.score);
                    check("best_hit", int'(best_hit), ms.bhit);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int id, score, thr, nhit;
        rst = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
        i_sw_id = '0; i_score = '0; i_thr = '0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        rst = 1'b1;

        // Single window: hit and frame_done both appear at cycle 4.
        i_ready = 1'b1;
        send(1130, 100, 50, 1);
        @(posedge clk); #1 i_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("lat_o_valid_c3", int'(o_valid), 0);
        check("lat_done_c3", int'(frame_done), 0);
        @(posedge clk);
        @(negedge clk);
        check("lat_o_valid_c4", int'(o_valid), 1);
        check("lat_done_c4", int'(frame_done), 1);
        @(negedge clk);
        check("done_one_cycle", int'(frame_done), 0);
        drain();

        // Full frame of valid windows, score = col - 20.
        for (int r = 14; r <= 28; r++)
            for (int c = 6; c <= 38; c++)
                send(r * 39 + c, c - 20, 0, 1);
        idle(1);
        drain();

        // Back-pressure: 20 hits into a stalled FIFO, last 4 dropped.
        i_ready = 1'b0;
        for (int i = 0; i < 20; i++) send(i, 10, 0, i < 16);
        send(1130, -1, 0, 1);
        idle(8);
        drain();

        // Full FIFO with a pop in the push cycle: no drop, occupancy stays full.
        i_ready = 1'b0;
        for (int i = 0; i < 16; i++) send(100 + i, 5, 0, 1);
        idle(6);
        send(116, 5, 0, 1);
        @(posedge clk); #1 i_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 i_ready = 1'b1;
        @(posedge clk); #1 i_ready = 1'b0;
        send(117, 5, 0, 0);
        send(1130, -100, 0, 1);
        idle(8);
        drain();

        // Negative scores and ties.
        send(1128, -5, -5, 1);
        send(1129, -6, -5, 1);
        send(1130, -5, -5, 1);
        idle(1);
        drain();

        // Reset mid-frame with a full FIFO; stale hits must vanish.
        i_ready = 1'b0;
        for (int i = 0; i < 100; i++) send(i, 7, 0, 0);
        @(posedge clk); #1 i_valid = 1'b0; rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_zero("midreset");
        rst = 1'b1;
        model_clear();
        i_ready = 1'b1;
        send(1130, 3, 0, 1);
        idle(1);
        drain();

        // Random frame, consumer always ready.
        id = $urandom_range(0, 30);
        while (id < int'(MAX_SW)) begin
            send(id, int'($urandom_range(0, 20)) - 10, int'($urandom_range(0, 10)) - 5, 1);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            id += $urandom_range(1, 8);
        end
        send(1130, int'($urandom_range(0, 20)) - 10, 0, 1);
        idle(1);
        drain();

        // Random frame, random ready, hits capped below FIFO depth so none drop.
        rand_ready = 1'b1;
        nhit = 0;
        id = $urandom_range(0, 30);
        while (id <= int'(MAX_SW)) begin
            if (id > int'(MAX_SW) - 9) id = int'(MAX_SW);
            thr = int'($urandom_range(0, 10)) - 5;
            score = int'($urandom_range(0, 30)) - 15;
            if (nhit >= 12) score = thr - 1;
            if (score >= thr) nhit++;
            send(id, score, thr, 1);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
            if (id == int'(MAX_SW)) break;
            id += $urandom_range(1, 9);
        end
        idle(1);
        rand_ready = 1'b0;
        drain();

        idle(4);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule

// File: doc/svm_det_collect.md
# svm_det_collect

Detection collector directly downstream of the SVM window controller and classifier. It takes one SVM score per valid slide window (tagged with its window index) and converts the index to (row, col). Scores at or above a programmable threshold are queued as hits in a small FIFO with a valid/ready output. At the end of each frame it reports a hit count, an overflow flag and the best-scoring window.

## Interface
- SW_W, 11, slide-window index width
- SC_W, 16, signed SVM score width
- COL_N, 39, windows per row
- MAX_SW, 1130, last window index of a frame
- FIFO_AW, 4, hit FIFO address width (depth 2^FIFO_AW = 16)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- i_valid  in  1  score valid (one window per assertion)
- i_sw_id  in  SW_W  window index of i_score
- i_score  in  SC_W  signed SVM score
- i_thr  in  SC_W  signed hit threshold, sampled with i_valid
- o_valid  out  1  hit FIFO not empty
- i_ready  in  1  consumer accepts head hit
- o_row  out  5  hit row
- o_col  out  6  hit column
- o_score  out  SC_W  hit score
- frame_done  out  1  one-cycle end-of-frame pulse
- frame_hits  out  SW_W  hits detected this frame, held until next frame_done
- frame_ovf  out  1  at least one hit dropped this frame, held
- best_row, best_col, best_score  out  5/6/SC_W  highest-scoring window of frame, held
- best_hit  out  1  best_score >= threshold, held

## Operation
- 3-stage pipeline; no stalls, so input is never back-pressured.
- S0: register i_valid, i_sw_id, i_score, i_thr.
- S1: row = (id × 1681) >> 16, an exact floor(id/39) for id ≤ 1130. The product is 22 bits unsigned.
- S2: col = id − row×39. hit = score >= thr, compared signed. The best-score tracker and hit counter update here.
- Hit path: a hit pushes {row, col, score} into the FIFO.
  - Full FIFO with i_ready=0: the hit is dropped and frame_ovf_acc is set.
  - Full FIFO with a pop in the same cycle: the push succeeds.
- FIFO pop: occurs when o_valid & i_ready. The head is first-word-fall-through.
- frame_hits_acc counts all hits, dropped ones included, and saturates at 2^SW_W−1.
- Best tracker:
  - The first valid window of a frame loads unconditionally.
  - Later windows replace it only on a strictly greater score, so ties keep the earlier window.
- Frame end occurs when S2 processes id == MAX_SW.
  - The next cycle: frame_done=1, and the summary outputs latch the accumulators.
  - The accumulators clear, and the tracker re-arms for "first window".
  - If that same cycle is a new valid S2 window, it initialises the new frame's accumulators.
- A non-monotonic or out-of-range id (> MAX_SW) is processed as data. Its row/col are undefined, and it never triggers frame end.
- State: an accumulator FSM with ARMED (no window yet this frame) and RUN. ARMED→RUN on the first S2 valid. RUN→ARMED on frame end.

## Timing
- Input-to-FIFO write: 3 cycles. The hit is visible on o_valid at cycle 4 after i_valid when the FIFO was empty.
- frame_done asserts 4 cycles after i_valid for id == MAX_SW.
- Reset (rst=0 at a clk edge) clears all outputs and state, mid-frame included:
  - o_valid=0, frame_done=0, frame_ovf=0, best_hit=0.
  - frame_hits, best_* and o_* all read 0.
  - The pipeline and FIFO are flushed, and the FSM returns to ARMED.
- Outputs o_row/o_col/o_score are stable while o_valid=1 and i_ready=0.

## Structure
- Shared package `hog_svm_pkg` holds COL_N, MAX_SW, ROW_W=5, COL_W=6, DIV39_MUL=1681 and DIV39_SH=16. svm_ctrl constants move there too.
- One sub-module, `det_fifo`: a synchronous FWFT FIFO with parameterised width/depth, count-based full/empty and simultaneous push/pop on full.

## Test plan
- Single window: id=1130, score=100, thr=50 → hit row 28, col 38, score 100 at cycle 4. frame_done at cycle 4, frame_hits=1, best=(28,38,100), best_hit=1.
- Full frame: all 495 valid windows (rows 14–28, cols 6–38) with score=col−20, thr=0, i_ready=1 → 15×19=285 hits in order. Every row/col is checked against id/39 and id%39. Best=(14,38,18) for the first max.
- Back-pressure: i_ready=0 and 20 consecutive hits → 16 queued, 4 dropped, frame_ovf=1, frame_hits=20. Draining yields the first 16 in order.
- Full with simultaneous pop: FIFO holds 16 and i_ready=1 while a hit arrives → no drop, occupancy stays 16.
- Negative scores and ties: thr=−5, scores −5, −6, −5 → hits for the 1st and 3rd. Best keeps the 1st (−5).
- Reset mid-frame: 100 windows, then rst=0 for 1 cycle, then the id 1130 window → frame_hits=1, no stale hits, all outputs 0 during reset.
